// File: rtl/load_store_sequencer.sv
// Load/store sequencer: turns one core access into one or two word-aligned
// req/gnt/rvalid bus beats, with byte enables, store shifting and load extension.
module load_store_sequencer #(
  parameter int unsigned TIMEOUT  = 255,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  input  logic [6:0]  lsu_opcode,
  input  logic [2:0]  lsu_fn3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned CW        = $clog2(TIMEOUT + 1);
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;

  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} state_t;

  state_t        state, state_n;
  logic          is_store_q, is_store_n;
  logic [2:0]    fn3_q, fn3_n;
  logic [1:0]    off_q, off_n;
  logic          split_q, split_n;
  logic [29:0]   waddr_q, waddr_n;
  logic [7:0]    mask_q, mask_n;
  logic [63:0]   data_q, data_n;
  logic          err_q, err_n;
  logic [31:0]   beat0_q, beat0_n, beat1_q, beat1_n;
  logic [CW-1:0] cnt_q, cnt_n;

  logic          lsu_busy_n, lsu_done_n, lsu_err_n, mem_req_n, mem_we_n;
  logic [31:0]   lsu_rdata_n, mem_addr_n, mem_wdata_n;
  logic [3:0]    mem_be_n;

  logic          dec_ok, dec_load, dec_store, dec_split;
  logic [3:0]    dec_size;
  logic [7:0]    dec_mask;
  logic          beat_ok;
  logic [31:0]   raw, ext;

  // Access decode of the incoming request (only consumed in IDLE)
  always_comb begin
    dec_load  = (lsu_opcode == OP_LOAD);
    dec_store = (lsu_opcode == OP_STORE);
    dec_ok    = 1'b1;
    dec_size  = 4'd4;
    case (lsu_fn3)
      3'b000:  dec_size = 4'd1;
      3'b001:  dec_size = 4'd2;
      3'b010:  dec_size = 4'd4;
      3'b011:  begin dec_size = 4'd1; dec_ok = dec_load; end
      3'b100:  begin dec_size = 4'd2; dec_ok = dec_load; end
      default: dec_ok = 1'b0;
    endcase
    dec_split = ({2'b00, lsu_addr[1:0]} + dec_size) > 4'd4;
    dec_mask  = 8'((8'd1 << dec_size) - 8'd1) << lsu_addr[1:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    is_store_n  = is_store_q;
    fn3_n       = fn3_q;
    off_n       = off_q;
    split_n     = split_q;
    waddr_n     = waddr_q;
    mask_n      = mask_q;
    data_n      = data_q;
    err_n       = err_q;
    beat0_n     = beat0_q;
    beat1_n     = beat1_q;
    cnt_n       = cnt_q + CW'(1);
    beat_ok     = 1'b0;
    lsu_busy_n  = 1'b0;
    lsu_done_n  = 1'b0;
    lsu_err_n   = 1'b0;
    lsu_rdata_n = '0;
    mem_req_n   = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = '0;
    mem_be_n    = '0;
    mem_wdata_n = '0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (lsu_valid && (dec_load || dec_store)) begin
          is_store_n = dec_store;
          fn3_n      = lsu_fn3;
          off_n      = lsu_addr[1:0];
          split_n    = dec_split;
          waddr_n    = lsu_addr[31:2];
          mask_n     = dec_mask;
          data_n     = 64'(lsu_wdata) << {lsu_addr[1:0], 3'b000};
          beat0_n    = '0;
          beat1_n    = '0;
          if (!dec_ok || (dec_split && !SPLIT_EN)) begin
            err_n   = 1'b1;
            state_n = S_RESP;
          end else begin
            err_n   = 1'b0;
            state_n = S_REQ0;
          end
        end
      end
      S_REQ0, S_WAIT0: begin
        // rvalid only counts once the grant has been seen (same cycle allowed)
        beat_ok = mem_rvalid && ((state == S_WAIT0) || mem_gnt);
        if (beat_ok) begin
          beat0_n = mem_rdata;
          state_n = split_q ? S_REQ1 : S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_RESP;
        end else if ((state == S_REQ0) && mem_gnt) begin
          state_n = S_WAIT0;
        end
      end
      S_REQ1, S_WAIT1: begin
        beat_ok = mem_rvalid && ((state == S_WAIT1) || mem_gnt);
        if (beat_ok) begin
          beat1_n = mem_rdata;
          state_n = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_RESP;
        end else if ((state == S_REQ1) && mem_gnt) begin
          state_n = S_WAIT1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (((state_n == S_REQ0) || (state_n == S_REQ1)) && (state_n != state)) begin
      cnt_n = '0;
    end

    raw = 32'({beat1_n, beat0_n} >> {off_q, 3'b000});
    case (fn3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b011:  ext = {24'b0, raw[7:0]};
      3'b100:  ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase

    lsu_busy_n = (state_n != S_IDLE);
    case (state_n)
      S_REQ0: begin
        mem_req_n   = 1'b1;
        mem_we_n    = is_store_n;
        mem_addr_n  = {waddr_n, 2'b00};
        mem_be_n    = mask_n[3:0];
        mem_wdata_n = data_n[31:0];
      end
      S_REQ1: begin
        mem_req_n   = 1'b1;
        mem_we_n    = is_store_n;
        mem_addr_n  = {waddr_n + 30'd1, 2'b00};
        mem_be_n    = mask_n[7:4];
        mem_wdata_n = data_n[63:32];
      end
      S_RESP: begin
        lsu_done_n = 1'b1;
        lsu_err_n  = err_n;
        if (!err_n && !is_store_n) lsu_rdata_n = ext;
      end
      default: ;
    endcase
  end

  // State, context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      is_store_q <= 1'b0;
      fn3_q      <= '0;
      off_q      <= '0;
      split_q    <= 1'b0;
      waddr_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      beat0_q    <= '0;
      beat1_q    <= '0;
      cnt_q      <= '0;
      lsu_busy   <= 1'b0;
      lsu_done   <= 1'b0;
      lsu_err    <= 1'b0;
      lsu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      is_store_q <= is_store_n;
      fn3_q      <= fn3_n;
      off_q      <= off_n;
      split_q    <= split_n;
      waddr_q    <= waddr_n;
      mask_q     <= mask_n;
      data_q     <= data_n;
      err_q      <= err_n;
      beat0_q    <= beat0_n;
      beat1_q    <= beat1_n;
      cnt_q      <= cnt_n;
      lsu_busy   <= lsu_busy_n;
      lsu_done   <= lsu_done_n;
      lsu_err    <= lsu_err_n;
      lsu_rdata  <= lsu_rdata_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_be     <= mem_be_n;
      mem_wdata  <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: byte-level memory model plus a bus responder
// with programmable grant/response delays; directed cases then random accesses.
module tb_load_store_sequencer;
  localparam int unsigned TMO    = 255;
  localparam int          MAXCYC = 400;
  localparam logic [6:0]  OP_LD  = 7'b0000011;
  localparam logic [6:0]  OP_ST  = 7'b0100011;

  logic        clk, rst_n;
  logic        lsu_valid, lsu_valid2;
  logic [6:0]  lsu_opcode;
  logic [2:0]  lsu_fn3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        b2_busy, b2_done, b2_err, b2_req, b2_we;
  logic [31:0] b2_rdata, b2_addr, b2_wdata;
  logic [3:0]  b2_be;
  logic        b2_gnt, b2_rvalid;
  logic [31:0] b2_mrdata;

  int n_chk, n_fail;

  load_store_sequencer #(.TIMEOUT(TMO), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_opcode(lsu_opcode),
    .lsu_fn3(lsu_fn3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_sequencer #(.TIMEOUT(TMO), .SPLIT_EN(1'b0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid2), .lsu_opcode(lsu_opcode),
    .lsu_fn3(lsu_fn3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(b2_busy), .lsu_done(b2_done), .lsu_err(b2_err), .lsu_rdata(b2_rdata),
    .mem_req(b2_req), .mem_we(b2_we), .mem_addr(b2_addr), .mem_be(b2_be),
    .mem_wdata(b2_wdata), .mem_gnt(b2_gnt), .mem_rvalid(b2_rvalid), .mem_rdata(b2_mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-side memory (written by DUT beats) and reference memory (written by model)
  logic [7:0] dmem [logic [31:0]];
  logic [7:0] rmem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] drd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] rrd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_byte(a);
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      dmem[a + 32'(k)] = w[8*k +: 8];
      rmem[a + 32'(k)] = w[8*k +: 8];
    end
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_busy",  lsu_busy,  0);
    chk("rst_done",  lsu_done,  0);
    chk("rst_err",   lsu_err,   0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_req",   mem_req,   0);
    chk("rst_we",    mem_we,    0);
    chk("rst_addr",  mem_addr,  0);
    chk("rst_be",    mem_be,    0);
    chk("rst_wdata", mem_wdata, 0);
  endtask

  // Access stimulus and observations
  logic [6:0]  a_op;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wd;
  int          a_gdly, a_rdly;
  bit          abort_w1;
  int          o_lat, o_beats, o_reqc;
  logic [31:0] o_rdata;
  logic        o_err;
  bit          o_done, o_aborted;
  logic [31:0] o_addr [2];
  logic [3:0]  o_be [2];
  logic [31:0] o_wd [2];
  logic        o_we [2];

  // Expected results
  bit          e_err, e_store;
  int          e_beats, e_lat, e_reqc;
  logic [31:0] e_rdata, e_addr0, e_addr1;
  logic [3:0]  e_be0, e_be1;

  task automatic model(input bit split_en);
    int sz;
    bit ok, mis;
    logic [31:0] raw, d;
    logic [7:0] be8;
    e_store = (a_op == OP_ST);
    ok = 1'b1;
    sz = 4;
    case (a_f3)
      3'd0: sz = 1;
      3'd1: sz = 2;
      3'd2: sz = 4;
      3'd3: begin sz = 1; ok = !e_store; end
      3'd4: begin sz = 2; ok = !e_store; end
      default: ok = 1'b0;
    endcase
    mis     = (int'(a_addr[1:0]) + sz) > 4;
    e_err   = !ok || (mis && !split_en);
    e_beats = e_err ? 0 : (mis ? 2 : 1);
    e_lat   = 1 + e_beats * (a_gdly + 1 + a_rdly);
    e_reqc  = e_beats * (a_gdly + 1);
    e_addr0 = a_addr & 32'hFFFF_FFFC;
    e_addr1 = e_addr0 + 32'd4;
    be8 = '0;
    for (int k = 0; k < 8; k++) begin
      d = (e_addr0 + 32'(k)) - a_addr;
      if (d < 32'(sz)) be8[k] = 1'b1;
    end
    e_be0 = be8[3:0];
    e_be1 = be8[7:4];
    e_rdata = '0;
    if (!e_err && !e_store) begin
      raw = '0;
      for (int k = 0; k < sz; k++) raw[8*k +: 8] = rrd(a_addr + 32'(k));
      case (a_f3)
        3'd0: e_rdata = 32'($signed(raw[7:0]));
        3'd1: e_rdata = 32'($signed(raw[15:0]));
        3'd3: e_rdata = 32'(raw[7:0]);
        3'd4: e_rdata = 32'(raw[15:0]);
        default: e_rdata = raw;
      endcase
    end
    if (!e_err && e_store) begin
      for (int k = 0; k < sz; k++) rmem[a_addr + 32'(k)] = a_wd[8*k +: 8];
    end
  endtask

  // Drives one access and plays the memory side until lsu_done (or abort)
  task automatic run_access();
    int ph, gc, rc, bi;
    logic [31:0] ba;
    ph = 0; gc = 0; rc = 0; bi = 0;
    o_done = 0; o_aborted = 0; o_beats = 0; o_reqc = 0; o_lat = 0;
    o_rdata = '0; o_err = 1'b0;
    @(negedge clk);
    chk("idle_busy", lsu_busy, 0);
    lsu_valid = 1'b1; lsu_opcode = a_op; lsu_fn3 = a_f3; lsu_addr = a_addr; lsu_wdata = a_wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int cyc = 1; cyc <= MAXCYC && !o_done && !o_aborted; cyc++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (lsu_done) begin
        o_done = 1; o_lat = cyc; o_rdata = lsu_rdata; o_err = lsu_err;
        chk("done_busy", lsu_busy, 1);
        chk("done_req", mem_req, 0);
        lsu_valid = 1'b0;
      end else if (abort_w1 && bi == 2 && ph == 2) begin
        rst_n = 1'b0;
        lsu_valid = 1'b0;
        #1;
        chk_zero();
        @(negedge clk);
        rst_n = 1'b1;
        o_aborted = 1;
      end else begin
        chk("busy", lsu_busy, 1);
        if (mem_req) o_reqc++;
        if (ph == 1)
          chk("req_hold", {mem_req, mem_addr, mem_be}, {1'b1, o_addr[bi-1], o_be[bi-1]});
        if (ph == 0 && mem_req) begin
          if (bi < 2) begin
            o_addr[bi] = mem_addr; o_be[bi] = mem_be; o_wd[bi] = mem_wdata; o_we[bi] = mem_we;
          end
          bi++;
          ph = 1; gc = a_gdly;
        end
        if (ph == 1) begin
          if (gc == 0) begin mem_gnt = 1'b1; ph = 2; rc = a_rdly; end
          else gc--;
        end
        if (ph == 2 && bi <= 2) begin
          if (rc == 0) begin
            mem_rvalid = 1'b1;
            ba = o_addr[bi-1];
            if (o_we[bi-1]) begin
              for (int k = 0; k < 4; k++)
                if (o_be[bi-1][k]) dmem[ba + 32'(k)] = o_wd[bi-1][8*k +: 8];
            end else begin
              mem_rdata = {drd(ba + 32'd3), drd(ba + 32'd2), drd(ba + 32'd1), drd(ba)};
            end
            o_beats++;
            ph = 0;
          end else rc--;
        end
      end
    end
    if (abort_w1) chk("abort_reached", o_aborted, 1);
    else chk("done_seen", o_done, 1);
    lsu_valid = 1'b0;
  endtask

  task automatic check_access();
    logic [95:0] wd_, wr_;
    chk("err", o_err, e_err);
    chk("rdata", o_rdata, e_rdata);
    chk("latency", o_lat, e_lat);
    chk("beats", o_beats, e_beats);
    chk("req_cycles", o_reqc, e_reqc);
    if (e_beats >= 1) begin
      chk("beat0_addr", o_addr[0], e_addr0);
      chk("beat0_be", o_be[0], e_be0);
      chk("beat0_we", o_we[0], e_store);
    end
    if (e_beats == 2) begin
      chk("beat1_addr", o_addr[1], e_addr1);
      chk("beat1_be", o_be[1], e_be1);
      chk("beat1_we", o_we[1], e_store);
    end
    for (int k = 0; k < 12; k++) begin
      wd_[8*k +: 8] = drd(a_addr - 32'd4 + 32'(k));
      wr_[8*k +: 8] = rrd(a_addr - 32'd4 + 32'(k));
    end
    chk("mem_window", wd_, wr_);
  endtask

  task automatic do_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gd, input int rd);
    a_op = op; a_f3 = f3; a_addr = a; a_wd = wd; a_gdly = gd; a_rdly = rd;
    model(1'b1);
    run_access();
    check_access();
  endtask

  initial begin
    bit st, got, seen_req;
    int lat2;
    logic e2;
    n_chk = 0; n_fail = 0; abort_w1 = 0;
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_valid2 = 1'b0;
    lsu_opcode = '0; lsu_fn3 = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    b2_gnt = 1'b0; b2_rvalid = 1'b0; b2_mrdata = '0;
    repeat (2) @(negedge clk);
    chk_zero();
    rst_n = 1'b1;

    // Unknown opcode and stray gnt/rvalid in IDLE are ignored
    @(negedge clk);
    lsu_valid = 1'b1; lsu_opcode = 7'h33; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("badop_busy", lsu_busy, 0);
      chk("badop_req", mem_req, 0);
    end
    lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    set_word(32'h100, 32'hDEAD_BEEF);
    do_access(OP_LD, 3'b010, 32'h100, 32'h0, 0, 1);
    chk("lw_addr", o_addr[0], 32'h100);
    chk("lw_be", o_be[0], 4'b1111);
    chk("lw_lat", o_lat, 3);
    chk("lw_rdata", o_rdata, 32'hDEAD_BEEF);

    set_word(32'h100, 32'h80FF_FFFF);
    do_access(OP_LD, 3'b000, 32'h103, 32'h0, 0, 1);
    chk("lb_be", o_be[0], 4'b1000);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    do_access(OP_LD, 3'b011, 32'h103, 32'h0, 0, 1);
    chk("lbu_rdata", o_rdata, 32'h0000_0080);

    do_access(OP_ST, 3'b001, 32'h203, 32'h0000_ABCD, 0, 1);
    chk("sh_a0", o_addr[0], 32'h200);
    chk("sh_be0", o_be[0], 4'b1000);
    chk("sh_wd0", o_wd[0], 32'hCD00_0000);
    chk("sh_a1", o_addr[1], 32'h204);
    chk("sh_be1", o_be[1], 4'b0001);
    chk("sh_wd1", o_wd[1], 32'h0000_00AB);

    set_word(32'h100, 32'h5678_AAAA);
    set_word(32'h104, 32'hBBBB_1234);
    do_access(OP_LD, 3'b010, 32'h102, 32'h0, 0, 1);
    chk("lw_split_rdata", o_rdata, 32'h1234_5678);
    chk("lw_split_lat", o_lat, 5);

    // Same misaligned word on the non-splitting instance
    @(negedge clk);
    lsu_opcode = OP_LD; lsu_fn3 = 3'b010; lsu_addr = 32'h102; lsu_valid2 = 1'b1;
    got = 0; seen_req = 0; lat2 = 0; e2 = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (b2_req) seen_req = 1;
      if (b2_done) begin got = 1; lat2 = c; e2 = b2_err; end
    end
    lsu_valid2 = 1'b0;
    chk("nosplit_done", got, 1);
    chk("nosplit_err", e2, 1);
    chk("nosplit_lat", lat2, 1);
    chk("nosplit_noreq", seen_req, 0);

    // Grant never arrives
    a_op = OP_LD; a_f3 = 3'b010; a_addr = 32'h300; a_wd = '0; a_gdly = TMO + 10; a_rdly = 0;
    run_access();
    chk("tmo_err", o_err, 1);
    chk("tmo_lat", o_lat, TMO + 1);
    chk("tmo_reqc", o_reqc, TMO);
    chk("tmo_beats", o_beats, 0);
    chk("tmo_rdata", o_rdata, 0);

    do_access(OP_LD, 3'b111, 32'h100, 32'h0, 0, 1);
    chk("badfn3_err", o_err, 1);
    chk("badfn3_lat", o_lat, 1);

    do_access(OP_LD, 3'b010, 32'hFFFF_FFFE, 32'h0, 1, 0);

    // Reset while waiting for the second beat, then a normal access
    abort_w1 = 1;
    a_op = OP_LD; a_f3 = 3'b010; a_addr = 32'h102; a_wd = '0; a_gdly = 0; a_rdly = 5;
    run_access();
    abort_w1 = 0;
    do_access(OP_LD, 3'b010, 32'h102, 32'h0, 0, 1);
    chk("post_rst_rdata", o_rdata, 32'h1234_5678);

    for (int i = 0; i < 80; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      st = ($urandom_range(0, 9) < 4);
      if (st) f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      else    f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                       : (32'h1000 + 32'($urandom_range(0, 63)));
      do_access(st ? OP_ST : OP_LD, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
